// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter for the register file write port with pending-write scoreboard
`timescale 1ns/1ps
module regfile_wb_arbiter #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 3,
    parameter int NREGS  = 2**AWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [AWIDTH-1:0] a_sel,
    input  logic [DWIDTH-1:0] a_data,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [AWIDTH-1:0] b_sel,
    input  logic [DWIDTH-1:0] b_data,
    output logic              b_ack,
    output logic              rf_we,
    output logic [AWIDTH-1:0] rf_wsel,
    output logic [DWIDTH-1:0] rf_wdata,
    input  logic              iss_valid,
    input  logic [AWIDTH-1:0] iss_sel,
    output logic [NREGS-1:0]  pend
);
    logic              rf_we_q, rf_we_d;
    logic [AWIDTH-1:0] rf_wsel_q, rf_wsel_d;
    logic [DWIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic              last_b_q, last_b_d;
    logic [NREGS-1:0]  clr_mask, set_mask;
    always_comb begin
        a_ack      = !reset && a_req && (!b_req || last_b_q);
        b_ack      = !reset && b_req && (!a_req || !last_b_q);
        rf_we_d    = a_ack || b_ack;
        rf_wsel_d  = a_ack ? a_sel : b_ack ? b_sel : rf_wsel_q;
        rf_wdata_d = a_ack ? a_data : b_ack ? b_data : rf_wdata_q;
        last_b_d   = a_ack ? 1'b0 : b_ack ? 1'b1 : last_b_q;
        clr_mask   = rf_we_q ? NREGS'(1) << rf_wsel_q : '0;
        set_mask   = iss_valid ? NREGS'(1) << iss_sel : '0;
        // set is OR'd after the clear so a same-index issue supersedes the commit
        pend_d     = (pend_q & ~clr_mask) | set_mask;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_wsel_q  <= '0;
            rf_wdata_q <= '0;
            pend_q     <= '0;
            last_b_q   <= 1'b1;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_wsel_q  <= rf_wsel_d;
            rf_wdata_q <= rf_wdata_d;
            pend_q     <= pend_d;
            last_b_q   <= last_b_d;
        end
    end
    assign rf_we    = rf_we_q;
    assign rf_wsel  = rf_wsel_q;
    assign rf_wdata = rf_wdata_q;
    assign pend     = pend_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req, iss_valid;
    logic [2:0]  a_sel, b_sel, iss_sel;
    logic [15:0] a_data, b_data;
    logic        a_ack, b_ack, rf_we;
    logic [2:0]  rf_wsel;
    logic [15:0] rf_wdata;
    logic [7:0]  pend;
    int          passed = 0;
    int          total = 0;
    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_sel(a_sel), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_sel(b_sel), .b_data(b_data), .b_ack(b_ack),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_sel(iss_sel), .pend(pend)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1'b1;
        a_req = 1'b1; a_sel = 3'd0; a_data = 16'h0;
        b_req = 1'b1; b_sel = 3'd0; b_data = 16'h0;
        iss_valid = 1'b0; iss_sel = 3'd0;
        #1;
        check("rst_a_ack", a_ack, 0);
        check("rst_b_ack", b_ack, 0);
        tick();
        tick();
        check("rst_we", rf_we, 0);
        check("rst_wsel", rf_wsel, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_pend", pend, 8'h00);
        check("rst_a_ack2", a_ack, 0);
        reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
        tick();
        check("idle_we", rf_we, 0);
        // single A write
        a_req = 1'b1; a_sel = 3'd3; a_data = 16'h1234;
        #1;
        check("single_a_ack", a_ack, 1);
        check("single_b_ack", b_ack, 0);
        tick();
        check("single_we", rf_we, 1);
        check("single_wsel", rf_wsel, 3);
        check("single_wdata", rf_wdata, 16'h1234);
        a_req = 1'b0;
        #1;
        check("single_ack_drop", a_ack, 0);
        tick();
        check("single_we_off", rf_we, 0);
        check("single_wsel_hold", rf_wsel, 3);
        check("single_wdata_hold", rf_wdata, 16'h1234);
        // continuous contention; A was last, so B leads
        a_req = 1'b1; a_sel = 3'd1; a_data = 16'hAAAA;
        b_req = 1'b1; b_sel = 3'd2; b_data = 16'hBBBB;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_a_ack", a_ack, (i % 2 == 1));
            check("rr_b_ack", b_ack, (i % 2 == 0));
            tick();
            check("rr_we", rf_we, 1);
            check("rr_wsel", rf_wsel, (i % 2 == 0) ? 2 : 1);
            check("rr_wdata", rf_wdata, (i % 2 == 0) ? 16'hBBBB : 16'hAAAA);
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();
        check("rr_we_off", rf_we, 0);
        // scoreboard set then clear via B commit
        iss_valid = 1'b1; iss_sel = 3'd5;
        tick();
        check("sb_set", pend, 8'h20);
        iss_valid = 1'b0;
        b_req = 1'b1; b_sel = 3'd5; b_data = 16'h5555;
        #1;
        check("sb_b_ack", b_ack, 1);
        tick();
        check("sb_commit_we", rf_we, 1);
        check("sb_n1", pend, 8'h20);
        b_req = 1'b0;
        tick();
        check("sb_n2", pend, 8'h00);
        // same-index set/clear collision
        b_req = 1'b1; b_sel = 3'd4; b_data = 16'h4444;
        iss_valid = 1'b1; iss_sel = 3'd4;
        tick();
        check("col_we", rf_we, 1);
        check("col_wsel", rf_wsel, 4);
        check("col_pend_set", pend, 8'h10);
        b_req = 1'b0;
        tick();
        check("col_set_wins", pend, 8'h10);
        // different-index set/clear
        iss_valid = 1'b0;
        a_req = 1'b1; a_sel = 3'd4; a_data = 16'h0004;
        tick();
        check("diff_we", rf_we, 1);
        check("diff_pend_pre", pend, 8'h10);
        a_req = 1'b0;
        iss_valid = 1'b1; iss_sel = 3'd6;
        tick();
        check("diff_pend", pend, 8'h40);
        iss_valid = 1'b0;
        // B alone for three cycles, then A wins contention
        b_req = 1'b1; b_sel = 3'd7; b_data = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bonly_b_ack", b_ack, 1);
            check("bonly_a_ack", a_ack, 0);
            tick();
            check("bonly_wsel", rf_wsel, 7);
        end
        a_req = 1'b1; a_sel = 3'd1; a_data = 16'h1111;
        #1;
        check("cont_a_ack", a_ack, 1);
        check("cont_b_ack", b_ack, 0);
        tick();
        check("cont_wdata", rf_wdata, 16'h1111);
        a_req = 1'b0; b_req = 1'b0;
        tick();
        check("nonpend_commit", pend, 8'h40);
        check("nonpend_we_off", rf_we, 0);
        // fill scoreboard, then reset with a command in flight
        iss_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            iss_sel = 3'(i);
            tick();
        end
        iss_valid = 1'b0;
        check("fill_pend", pend, 8'hFF);
        a_req = 1'b1; a_sel = 3'd2; a_data = 16'h2222;
        tick();
        check("inflight_we", rf_we, 1);
        reset = 1'b1; b_req = 1'b1; b_sel = 3'd2; b_data = 16'hBBBB;
        a_sel = 3'd1; a_data = 16'hAAAA;
        #1;
        check("midrst_a_ack", a_ack, 0);
        check("midrst_b_ack", b_ack, 0);
        tick();
        check("midrst_we", rf_we, 0);
        check("midrst_pend", pend, 8'h00);
        reset = 1'b0;
        #1;
        check("post_a_ack", a_ack, 1);
        check("post_b_ack", b_ack, 0);
        tick();
        check("post_wsel", rf_wsel, 1);
        check("post_wdata", rf_wdata, 16'hAAAA);
        a_req = 1'b0; b_req = 1'b0;
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
